aes_decrypt_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 108 ++++++++++
 rtl/aes_decrypt_iter_if.sv | 28 ++
 rtl/aes_inv_round.sv | 40 ++++
 rtl/aes_decrypt_iter.sv | 157 +++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : AES tables, GF(2^8) helpers, key-schedule steps and FSM type
//               shared by the iterative AES-128 decryptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte 0 of each table sits in the most significant byte.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [10:1][7:0] c_rcon = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return c_sbox[idx +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return c_inv_sbox[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one forward step: rk_r -> rk_(r-1), using rcon[r].
    function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_decrypt_iter_if.sv
// ============================================================================
// Module      : aes_decrypt_iter_if
// Description : valid/ready ciphertext-in / plaintext-out bus of the decryptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    modport master (
        output in_valid, data_in, key, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, key, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

`default_nettype wire

// File: rtl/aes_inv_round.sv
// ============================================================================
// Module      : aes_inv_round
// Description : combinational AES inverse round; InvMixColumns skipped on the
//               last round.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last_round,
    output logic [127:0] next_state
);

    logic [127:0] w_sub;
    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // Row r rotates right by r columns; byte index is row + 4*column.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int c_src = r + 4 * ((c - r + 4) % 4);
            assign w_sub[127-8*(r+4*c) -: 8] = inv_sbox(state[127-8*c_src -: 8]);
        end
    end

    assign w_ark = w_sub ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end

    assign next_state = last_round ? w_ark : w_mix;

endmodule

`default_nettype wire

// File: rtl/aes_decrypt_iter.sv
// ============================================================================
// Module      : aes_decrypt_iter
// Description : iterative AES-128 decryptor, one round per clock, round keys
//               expanded on the fly. Optional macro AES_DEC_KEY_CACHE_EN keeps
//               the last key/rk10 pair so a repeated key skips expansion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_decrypt_iter #(
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_decrypt_iter_if.slave bus
);
    import aes_pkg::*;

    if (NR != aes_pkg::NR) begin : g_bad_nr
        $error("aes_decrypt_iter: only NR=10 (AES-128) is supported");
    end

    state_t       r_fsm, w_fsm_nxt;
    logic [127:0] r_state, w_state_nxt;
    logic [127:0] r_rk, w_rk_nxt;
    logic [127:0] r_dout, w_dout_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic         r_out_valid, w_out_valid_nxt;
    logic         r_alive;
    logic [127:0] w_round_out;
    logic [127:0] w_rk_fwd;
    logic [127:0] w_rk_inv;
    logic         w_accept;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] r_key_cache, w_key_cache_nxt;
    logic [127:0] r_rk10_cache, w_rk10_cache_nxt;
    logic         r_cache_vld, w_cache_vld_nxt;
`endif

    aes_inv_round u_round (
        .state      (r_state),
        .rk         (r_rk),
        .last_round (r_cnt == 4'd10),
        .next_state (w_round_out)
    );

    assign w_rk_fwd      = key_fwd(r_rk, c_rcon[r_cnt + 4'd1]);
    assign w_rk_inv      = key_inv(r_rk, c_rcon[4'd10 - r_cnt]);
    // r_alive keeps in_ready low through reset and for no longer than one edge after.
    assign bus.in_ready  = r_alive && (r_fsm == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_dout;
    assign w_accept      = bus.in_valid && bus.in_ready;

    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_state_nxt     = r_state;
        w_rk_nxt        = r_rk;
        w_dout_nxt      = r_dout;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
`ifdef AES_DEC_KEY_CACHE_EN
        w_key_cache_nxt  = r_key_cache;
        w_rk10_cache_nxt = r_rk10_cache;
        w_cache_vld_nxt  = r_cache_vld;
`endif
        unique case (r_fsm)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.data_in;
                    w_rk_nxt    = bus.key;
                    w_cnt_nxt   = 4'd0;
                    w_fsm_nxt   = KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (r_cache_vld && (bus.key == r_key_cache)) begin
                        w_rk_nxt  = r_rk10_cache;
                        w_fsm_nxt = ROUND;
                    end else begin
                        w_key_cache_nxt = bus.key;
                        w_cache_vld_nxt = 1'b0;
                    end
`endif
                end
            end
            KEXP: begin
                w_rk_nxt = w_rk_fwd;
                if (r_cnt == 4'd9) begin
                    w_cnt_nxt = 4'd0;
                    w_fsm_nxt = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                    w_rk10_cache_nxt = w_rk_fwd;
                    w_cache_vld_nxt  = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ROUND: begin
                w_state_nxt = (r_cnt == 4'd0) ? (r_state ^ r_rk) : w_round_out;
                if (r_cnt == 4'd10) begin
                    w_dout_nxt      = w_round_out;
                    w_out_valid_nxt = 1'b1;
                    w_cnt_nxt       = 4'd0;
                    w_fsm_nxt       = DONE;
                end else begin
                    w_rk_nxt  = w_rk_inv;
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_fsm_nxt       = IDLE;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_rk        <= '0;
            r_dout      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_alive     <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_state     <= w_state_nxt;
            r_rk        <= w_rk_nxt;
            r_dout      <= w_dout_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_alive     <= 1'b1;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_cache  <= '0;
            r_rk10_cache <= '0;
            r_cache_vld  <= 1'b0;
        end else begin
            r_key_cache  <= w_key_cache_nxt;
            r_rk10_cache <= w_rk10_cache_nxt;
            r_cache_vld  <= w_cache_vld_nxt;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
// ============================================================================
// Module      : tb_aes_decrypt_iter
// Description : directed-vector bench for aes_decrypt_iter (latency, data,
//               backpressure, busy-ignore, reset abort, key cache).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_decrypt_iter;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_decrypt_iter_if bus ();

    aes_decrypt_iter #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           hold;
        int           glitch;
    } vec_t;

    vec_t         tbl [6];
    int           n_chk = 0;
    int           n_fail = 0;
    bit           m_vld = 1'b0;
    logic [127:0] m_key = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction from a negedge: accept, latency, data, optional hold, release.
    task automatic do_txn(input vec_t v);
        int n;
        int exp_lat;
        exp_lat = (CACHE_EN && m_vld && (v.key == m_key)) ? 11 : 21;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, " in_ready before accept"}, 128'(bus.in_ready), 128'd1);
        bus.key       = v.key;
        bus.data_in   = v.ct;
        bus.in_valid  = 1'b1;
        bus.out_ready = (v.hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(negedge clk);
            n++;
            if (v.glitch != 0 && n == 3) begin
                bus.key      = B_KEY;
                bus.data_in  = B_CT;
                bus.in_valid = 1'b1;
            end else if (n == 4) begin
                bus.in_valid = 1'b0;
            end
        end
        if (exp_lat == 21) begin
            m_vld = 1'b1;
            m_key = v.key;
        end
        chk({v.name, " latency"}, 128'(n), 128'(exp_lat));
        chk({v.name, " data_out"}, bus.data_out, v.pt);
        chk({v.name, " in_ready low while out_valid"}, 128'(bus.in_ready), 128'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk({v.name, " hold out_valid"}, 128'(bus.out_valid), 128'd1);
            chk({v.name, " hold data_out"}, bus.data_out, v.pt);
            chk({v.name, " hold in_ready"}, 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({v.name, " out_valid drop"}, 128'(bus.out_valid), 128'd0);
        chk({v.name, " in_ready after handshake"}, 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"fips_c1",  C1_KEY, C1_CT, C1_PT, 0, 0};
        tbl[1] = '{"fips_b",   B_KEY,  B_CT,  B_PT,  0, 0};
        tbl[2] = '{"zero_bp",  '0,     Z_CT,  '0,    5, 0};
        tbl[3] = '{"busy_ign", C1_KEY, C1_CT, C1_PT, 0, 1};
        tbl[4] = '{"c1_again", C1_KEY, C1_CT, C1_PT, 0, 0};
        tbl[5] = '{"b_again",  B_KEY,  B_CT,  B_PT,  0, 0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.data_in   = '0;
        bus.key       = '0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", 128'(bus.in_ready), 128'd0);
        chk("reset out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset data_out", bus.data_out, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after release", 128'(bus.in_ready), 128'd1);

        for (int i = 0; i < 6; i++) do_txn(tbl[i]);

        // Abort in ROUND with cnt=4 (14 edges after the accept edge).
        bus.key      = C1_KEY;
        bus.data_in  = C1_CT;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        m_vld = 1'b0;
        #1;
        chk("abort out_valid", 128'(bus.out_valid), 128'd0);
        chk("abort in_ready", 128'(bus.in_ready), 128'd0);
        chk("abort data_out", bus.data_out, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-abort in_ready", 128'(bus.in_ready), 128'd1);
        chk("post-abort out_valid", 128'(bus.out_valid), 128'd0);
        do_txn('{"post_abort_c1", C1_KEY, C1_CT, C1_PT, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
